// File: rtl/reset_seq.sv
// reset_seq: multi-channel reset sequencer with synchronised release, staggered channel deassertion
// and per-channel soft resets. Define RESET_SEQ_CAUSE_EN to add the 'cause' output.
module reset_seq #(
  parameter int CHANNELS    = 3,
  parameter int LENGTH      = 5,
  parameter int GAP         = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                ck,
  input  logic                rst_n,
  input  logic                rst_req,
  input  logic [CHANNELS-1:0] chan_req,
  output logic [CHANNELS-1:0] rst,
  output logic                done
`ifdef RESET_SEQ_CAUSE_EN
  ,
  output logic [1:0]          cause
`endif
);

  localparam int MAX_CNT = (LENGTH > GAP) ? LENGTH : GAP;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int SW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  // Counters fire on the last count so a release lands exactly LENGTH/GAP edges later.
  localparam logic [CW-1:0] LEN_LAST   = CW'(LENGTH - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);
  localparam logic [SW-1:0] STAGE_LAST = SW'(CHANNELS - 1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t                       state_q, state_nxt;
  logic [CW-1:0]                cnt_q, cnt_nxt;
  logic [SW-1:0]                stage_q, stage_nxt;
  logic [CHANNELS-1:0]          rst_q, rst_nxt;
  logic                         done_q, done_nxt;
  logic [CHANNELS-1:0][CW-1:0]  ch_cnt_q, ch_cnt_nxt;
  logic [SYNC_STAGES-1:0]       sync_q;
  logic                         rst_sync;

  // rst_n deassertion synchroniser; assertion is immediate through the async clear
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HOLD;
      cnt_q    <= '0;
      stage_q  <= '0;
      rst_q    <= '1;
      done_q   <= 1'b0;
      ch_cnt_q <= '0;
    end else begin
      state_q  <= state_nxt;
      cnt_q    <= cnt_nxt;
      stage_q  <= stage_nxt;
      rst_q    <= rst_nxt;
      done_q   <= done_nxt;
      ch_cnt_q <= ch_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    stage_nxt  = stage_q;
    rst_nxt    = rst_q;
    done_nxt   = done_q;
    ch_cnt_nxt = ch_cnt_q;

    if (rst_req) begin
      state_nxt  = HOLD;
      cnt_nxt    = '0;
      stage_nxt  = '0;
      rst_nxt    = '1;
      done_nxt   = 1'b0;
      ch_cnt_nxt = '0;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (rst_sync) begin
            if (cnt_q == LEN_LAST) begin
              rst_nxt[0] = 1'b0;
              cnt_nxt    = '0;
              stage_nxt  = SW'(1);
              if (CHANNELS == 1) begin
                state_nxt = RUN;
                done_nxt  = 1'b1;
              end else begin
                state_nxt = RELEASE;
              end
            end else begin
              cnt_nxt = cnt_q + CW'(1);
            end
          end
        end

        RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            rst_nxt[stage_q] = 1'b0;
            cnt_nxt          = '0;
            if (stage_q == STAGE_LAST) begin
              state_nxt = RUN;
              done_nxt  = 1'b1;
            end else begin
              stage_nxt = stage_q + SW'(1);
            end
          end else begin
            cnt_nxt = cnt_q + CW'(1);
          end
        end

        RUN: begin
          // Each channel runs its own pulse; a new request restarts the count.
          for (int i = 0; i < CHANNELS; i++) begin
            if (chan_req[i]) begin
              rst_nxt[i]    = 1'b1;
              ch_cnt_nxt[i] = '0;
            end else if (rst_q[i]) begin
              if (ch_cnt_q[i] == LEN_LAST) begin
                rst_nxt[i]    = 1'b0;
                ch_cnt_nxt[i] = '0;
              end else begin
                ch_cnt_nxt[i] = ch_cnt_q[i] + CW'(1);
              end
            end
          end
        end

        default: begin
          state_nxt = HOLD;
        end
      endcase
    end
  end

  assign rst  = rst_q;
  assign done = done_q;

`ifdef RESET_SEQ_CAUSE_EN
  logic [1:0] cause_q;
  logic       chan_acc;

  assign chan_acc = (state_q == RUN) && !rst_req && (|chan_req);

  // 1 = board reset, 2 = soft full request, 3 = channel request
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      cause_q <= 2'd1;
    end else if (rst_req) begin
      cause_q <= 2'd2;
    end else if (chan_acc) begin
      cause_q <= 2'd3;
    end
  end

  assign cause = cause_q;
`endif

endmodule

// File: tb/tb_reset_seq.sv
// tb_reset_seq: randomized and directed bench for reset_seq against a timing-rule reference model.
module tb_reset_seq;

  localparam int C     = 3;
  localparam int L     = 5;
  localparam int G     = 2;
  localparam int S     = 2;
  localparam int TDONE = L + (C - 1) * G;

  logic         ck;
  logic         rst_n;
  logic         rst_req;
  logic [C-1:0] chan_req;
  logic [C-1:0] rst;
  logic         done;
`ifdef RESET_SEQ_CAUSE_EN
  logic [1:0]   cause;
`endif

  int tests_run;
  int tests_failed;

  // Reference model: q = qualifying quiet edges since the last reset event,
  // last_e[i] = edge number of the last accepted channel request.
  int           n;
  int           q;
  int           sync_cnt;
  int           last_e [C];
  logic [1:0]   m_cause;
  logic [C-1:0] exp_rst;
  logic         exp_done;

  reset_seq #(
    .CHANNELS    (C),
    .LENGTH      (L),
    .GAP         (G),
    .SYNC_STAGES (S)
  ) dut (
    .ck       (ck),
    .rst_n    (rst_n),
    .rst_req  (rst_req),
    .chan_req (chan_req),
    .rst      (rst),
    .done     (done)
`ifdef RESET_SEQ_CAUSE_EN
    ,
    .cause    (cause)
`endif
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic recompute();
    for (int i = 0; i < C; i++) begin
      exp_rst[i] = (q < L + i * G) || ((n - last_e[i]) < L);
    end
    exp_done = (q >= TDONE);
  endtask

  task automatic model_async_reset();
    q        = 0;
    sync_cnt = 0;
    for (int i = 0; i < C; i++) last_e[i] = -1000;
    m_cause  = 2'd1;
    recompute();
  endtask

  task automatic tick(input logic rq, input logic [C-1:0] cr);
    logic counting;
    rst_req  = rq;
    chan_req = cr;
    @(posedge ck);
    #1;
    n++;
    if (rst_n) begin
      counting = (sync_cnt >= S);
      if (!counting) sync_cnt++;
      if (rq) begin
        q = 0;
        for (int i = 0; i < C; i++) last_e[i] = -1000;
        m_cause = 2'd2;
      end else begin
        if (q >= TDONE && cr != '0) begin
          for (int i = 0; i < C; i++) if (cr[i]) last_e[i] = n;
          m_cause = 2'd3;
        end
        if (counting && q < 100000) q++;
      end
    end
    recompute();
  endtask

  task automatic test_reset();
    logic [C-1:0] want;
    #2 rst_n = 1'b0;
    #1;
    model_async_reset();
    tests_run++;
    if (rst !== 3'b111 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async rst=%b done=%b expected rst=111 done=0", rst, done);
    end
`ifdef RESET_SEQ_CAUSE_EN
    tests_run++;
    if (cause !== 2'd1) begin
      tests_failed++;
      $display("FAIL reset_cause cause=%0d expected 1", cause);
    end
`endif
    tick(1'b0, '0);
    tick(1'b0, '0);
    tests_run++;
    if (rst !== 3'b111 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_held rst=%b done=%b expected rst=111 done=0", rst, done);
    end
    #2 rst_n = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick(1'b0, '0);
      for (int i = 0; i < C; i++) want[i] = (k < S + L + i * G);
      tests_run++;
      if (rst !== want || done !== (k >= S + TDONE)) begin
        tests_failed++;
        $display("FAIL powerup_edge%0d rst=%b done=%b expected rst=%b done=%b",
                 k, rst, done, want, (k >= S + TDONE));
      end
    end
  endtask

  task automatic test_rst_req();
    logic [C-1:0] want;
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, '0);
      tests_run++;
      if (rst !== 3'b111 || done !== 1'b0) begin
        tests_failed++;
        $display("FAIL rst_req_hold%0d rst=%b done=%b expected rst=111 done=0", k, rst, done);
      end
    end
    for (int j = 1; j <= 12; j++) begin
      tick(1'b0, '0);
      for (int i = 0; i < C; i++) want[i] = (j < L + i * G);
      tests_run++;
      if (rst !== want || done !== (j >= TDONE)) begin
        tests_failed++;
        $display("FAIL rst_req_edge%0d rst=%b done=%b expected rst=%b done=%b",
                 j, rst, done, want, (j >= TDONE));
      end
    end
`ifdef RESET_SEQ_CAUSE_EN
    tests_run++;
    if (cause !== 2'd2) begin
      tests_failed++;
      $display("FAIL rst_req_cause cause=%0d expected 2", cause);
    end
`endif
  endtask

  task automatic test_chan_req();
    for (int j = 0; j <= 6; j++) begin
      tick(1'b0, (j == 0) ? 3'b010 : 3'b000);
      tests_run++;
      if (rst !== ((j < L) ? 3'b010 : 3'b000) || done !== 1'b1) begin
        tests_failed++;
        $display("FAIL chan_req_edge%0d rst=%b done=%b expected rst=%b done=1",
                 j, rst, done, (j < L) ? 3'b010 : 3'b000);
      end
    end
`ifdef RESET_SEQ_CAUSE_EN
    tests_run++;
    if (cause !== 2'd3) begin
      tests_failed++;
      $display("FAIL chan_req_cause cause=%0d expected 3", cause);
    end
`endif
  endtask

  task automatic test_retrigger();
    tick(1'b0, 3'b100);
    tick(1'b0, 3'b000);
    tick(1'b0, 3'b000);
    for (int j = 0; j <= 6; j++) begin
      tick(1'b0, (j == 0) ? 3'b100 : 3'b000);
      tests_run++;
      if (rst !== ((j < L) ? 3'b100 : 3'b000) || done !== 1'b1) begin
        tests_failed++;
        $display("FAIL retrigger_edge%0d rst=%b done=%b expected rst=%b done=1",
                 j, rst, done, (j < L) ? 3'b100 : 3'b000);
      end
    end
  endtask

  task automatic test_chan_and_rst_req();
    logic [C-1:0] want;
    tick(1'b1, 3'b001);
    tests_run++;
    if (rst !== 3'b111 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL both_req_first rst=%b done=%b expected rst=111 done=0", rst, done);
    end
    for (int j = 1; j <= 12; j++) begin
      tick(1'b0, '0);
      for (int i = 0; i < C; i++) want[i] = (j < L + i * G);
      tests_run++;
      if (rst !== want || done !== (j >= TDONE)) begin
        tests_failed++;
        $display("FAIL both_req_edge%0d rst=%b done=%b expected rst=%b done=%b",
                 j, rst, done, want, (j >= TDONE));
      end
    end
  endtask

  task automatic test_release_ignore();
    logic [C-1:0] want;
    tick(1'b1, '0);
    for (int j = 1; j <= 12; j++) begin
      tick(1'b0, (j <= TDONE) ? C'($urandom_range(1, (1 << C) - 1)) : '0);
      for (int i = 0; i < C; i++) want[i] = (j < L + i * G);
      tests_run++;
      if (rst !== want || done !== (j >= TDONE)) begin
        tests_failed++;
        $display("FAIL release_ignore_edge%0d rst=%b done=%b expected rst=%b done=%b",
                 j, rst, done, want, (j >= TDONE));
      end
    end
    // rst_n pulse in the middle of a release sequence
    tick(1'b1, '0);
    for (int j = 1; j <= 6; j++) tick(1'b0, '0);
    #2 rst_n = 1'b0;
    #1;
    model_async_reset();
    tests_run++;
    if (rst !== 3'b111 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_release_async rst=%b done=%b expected rst=111 done=0", rst, done);
    end
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick(1'b0, '0);
      for (int i = 0; i < C; i++) want[i] = (k < S + L + i * G);
      tests_run++;
      if (rst !== want || done !== (k >= S + TDONE)) begin
        tests_failed++;
        $display("FAIL restart_edge%0d rst=%b done=%b expected rst=%b done=%b",
                 k, rst, done, want, (k >= S + TDONE));
      end
    end
  endtask

  task automatic test_random();
    logic         rq;
    logic [C-1:0] cr;
    for (int k = 0; k < 600; k++) begin
      rq = ($urandom_range(0, 79) == 0);
      cr = ($urandom_range(0, 3) == 0) ? C'($urandom_range(0, (1 << C) - 1)) : '0;
      tick(rq, cr);
      tests_run++;
      if (rst !== exp_rst || done !== exp_done) begin
        tests_failed++;
        $display("FAIL random_edge%0d rst=%b done=%b expected rst=%b done=%b",
                 k, rst, done, exp_rst, exp_done);
      end
`ifdef RESET_SEQ_CAUSE_EN
      tests_run++;
      if (cause !== m_cause) begin
        tests_failed++;
        $display("FAIL random_cause%0d cause=%0d expected %0d", k, cause, m_cause);
      end
`endif
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    n            = 0;
    rst_n        = 1'b1;
    rst_req      = 1'b0;
    chan_req     = '0;
    model_async_reset();
    @(posedge ck);
    #1;
    test_reset();
    test_rst_req();
    test_chan_req();
    test_retrigger();
    test_chan_and_rst_req();
    test_release_ignore();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
